// File: rtl/imm_narrow_pipe.sv
// Two-stage valid/ready pipeline that narrows a signed IN_W value to an OUT_W immediate,
// saturating or wrapping unrepresentable values and counting delivered overflows.
module imm_narrow_pipe #(
   parameter int IN_W  = 6,
   parameter int OUT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             clr_count
);

   localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             s1_valid_q, s1_valid_d;
   logic [IN_W-1:0]  s1_data_q,  s1_data_d;
   logic             s1_sat_q,   s1_sat_d;
   logic             s2_valid_q, s2_valid_d;
   logic [OUT_W-1:0] s2_data_q,  s2_data_d;
   logic             s2_ovf_q,   s2_ovf_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   logic                  adv1, adv2;
   logic                  fits;
   logic [IN_W-OUT_W:0]   hi_bits;
   logic [OUT_W-1:0]      narrowed;

   assign adv2     = !s2_valid_q || out_ready;
   assign adv1     = !s1_valid_q || adv2;
   assign in_ready = adv1;

   // A value fits when every bit from the output sign position upward is a copy of the sign.
   assign hi_bits = s1_data_q[IN_W-1:OUT_W-1];
   assign fits    = (&hi_bits) || !(|hi_bits);

   always_comb begin
      if (fits || !s1_sat_q) begin
         narrowed = s1_data_q[OUT_W-1:0];
      end else begin
         narrowed = s1_data_q[IN_W-1] ? MIN_NEG : MAX_POS;
      end
   end

   always_comb begin
      // NOTE: every next-state variable gets its hold value first so no path infers a latch.
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_sat_d   = s1_sat_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_ovf_d   = s2_ovf_q;
      cnt_d      = cnt_q;

      if (adv1) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = in_data;
            s1_sat_d  = in_sat;
         end
      end

      if (adv2) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = narrowed;
            s2_ovf_d  = !fits;
         end
      end

      // Clear wins over a same-cycle overflow delivery; the count sticks at all-ones.
      if (clr_count) begin
         cnt_d = '0;
      end else if (s2_valid_q && out_ready && s2_ovf_q && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_sat_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_ovf_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_sat_q   <= s1_sat_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_ovf_q   <= s2_ovf_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_ovf   = s2_ovf_q;
   assign ovf_count = cnt_q;

endmodule
